// File: rtl/psa_pipe.sv
// Parallel signed sub-word add/subtract with per-instruction saturate/wrap,
// a two-stage elastic valid/ready pipeline, and sticky overflow tracking.
module psa_pipe #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANE_W*LANES-1:0]   a,
  input  logic [LANE_W*LANES-1:0]   b,
  input  logic                      sub,
  input  logic                      sat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANE_W*LANES-1:0]   sum,
  output logic [LANES-1:0]          lane_ovf,
  output logic                      error,
  output logic                      err_sticky,
  input  logic                      clr_err,
  output logic [CNT_W-1:0]          ovf_cnt
);

  localparam int DATA_W = LANE_W * LANES;
  localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};
  localparam logic [LANE_W-1:0] LANE_MAX = ~LANE_MIN;
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic              s1_sub;
  logic              s1_sat;

  logic              s2_free;
  logic              s1_adv;
  logic              in_xfer;
  logic              out_xfer;

  logic [DATA_W-1:0] calc_sum;
  logic [LANES-1:0]  calc_ovf;
  logic [LANE_W-1:0] la;
  logic [LANE_W-1:0] lb;
  logic [LANE_W-1:0] lr;

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  // Gated by rst_n so nothing is accepted while the pipe is being flushed.
  assign in_ready = rst_n && (!s1_valid || s2_free);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Subtract is A + ~B + 1, so one overflow rule covers both: operands of the
  // same sign producing a result of the other sign.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    calc_sum = '0;
    calc_ovf = '0;
    la       = '0;
    lb       = '0;
    lr       = '0;
    for (int i = 0; i < LANES; i++) begin
      la = s1_a[i*LANE_W +: LANE_W];
      lb = s1_sub ? ~s1_b[i*LANE_W +: LANE_W] : s1_b[i*LANE_W +: LANE_W];
      lr = la + lb + LANE_W'(s1_sub);
      calc_ovf[i] = (la[LANE_W-1] == lb[LANE_W-1]) && (lr[LANE_W-1] != la[LANE_W-1]);
      if (s1_sat && calc_ovf[i])
        calc_sum[i*LANE_W +: LANE_W] = la[LANE_W-1] ? LANE_MIN : LANE_MAX;
      else
        calc_sum[i*LANE_W +: LANE_W] = lr;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n)
      s1_valid <= 1'b0;
    else if (in_xfer)
      s1_valid <= 1'b1;
    else if (s1_adv)
      s1_valid <= 1'b0;
  end

  // NOTE: S1 operand registers need no reset; s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_a   <= a;
      s1_b   <= b;
      s1_sub <= sub;
      s1_sat <= sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      lane_ovf  <= '0;
      error     <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      sum       <= calc_sum;
      lane_ovf  <= calc_ovf;
      error     <= |calc_ovf;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  // A new error event beats a coincident clear: clear, then count it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else if (out_xfer && error) begin
      err_sticky <= 1'b1;
      if (clr_err)
        ovf_cnt <= CNT_W'(1);
      else if (ovf_cnt != CNT_MAX)
        ovf_cnt <= ovf_cnt + CNT_W'(1);
    end else if (clr_err) begin
      err_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end
  end

endmodule
